cp0_regfile: RTL and testbench

- Coprocessor-0 register file; sits directly downstream of the exception detection stage.
- Consumes the detector's exception-entry bundle (enable, code, EPC, BD, bad vaddr) and its ERET EXL-clear, plus MTC0/MFC0 traffic from the memory stage.
- Holds BadVAddr, Count, Compare, Status, Cause, EPC and PRId.
- Produces EPC for ERET redirection, the EXL state, and the interrupt request back to the detector.

---
 rtl/cp0_regfile.sv | 164 ++++++++++++++++
 tb/tb_cp0_regfile.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_regfile.sv
// cp0_regfile: coprocessor-0 registers behind the exception detector.
// Holds BadVAddr/Count/Compare/Status/Cause/EPC/PRId and raises the interrupt request.
module cp0_regfile #(
    parameter logic [31:0] PRID_VALUE = 32'h0001_8000,
    parameter bit          COUNT_DIV2 = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata,
    input  logic        wen,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [5:0]  hw_int,
    input  logic        cp0_exp_en,
    input  logic        cp0_exl_clean,
    input  logic [31:0] cp0_exp_epc,
    input  logic [4:0]  cp0_exp_code,
    input  logic        cp0_exp_bd,
    input  logic [31:0] cp0_exp_bad_vaddr,
    input  logic        cp0_exp_bad_vaddr_wen,
    output logic [31:0] epc_address,
    output logic        status_exl,
    output logic        interrupt_pending,
    output logic        timer_int
);

    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] epc_q, epc_d;
    logic [7:0]  im_q, im_d;
    logic [7:0]  ip_q, ip_d;
    logic [4:0]  code_q, code_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic        ti_q, ti_d;
    logic        tog_q, tog_d;

    logic        wr_count, wr_cmp, wr_status, wr_cause, wr_epc;
    logic        cnt_inc, first_exc;
    logic [31:0] count_nxt;
    logic [31:0] status_w, cause_w;

    assign wr_count  = wen && (waddr == 5'd9);
    assign wr_cmp    = wen && (waddr == 5'd11);
    assign wr_status = wen && (waddr == 5'd12);
    assign wr_cause  = wen && (waddr == 5'd13);
    assign wr_epc    = wen && (waddr == 5'd14);

    assign cnt_inc   = COUNT_DIV2 ? tog_q : 1'b1;
    assign count_nxt = count_q + 32'd1;
    // EPC and BD are only captured for the outermost exception
    assign first_exc = cp0_exp_en && !exl_q;

    always_comb begin
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        compare_d  = compare_q;
        epc_d      = epc_q;
        im_d       = im_q;
        ip_d       = ip_q;
        code_d     = code_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ti_d       = ti_q;
        tog_d      = wr_count ? 1'b0 : ~tog_q;

        if (wr_count)
            count_d = wdata;
        else if (cnt_inc)
            count_d = count_nxt;

        if (wr_cmp)
            compare_d = wdata;

        // a Compare write clears TI even when a match lands on the same edge
        if (wr_cmp)
            ti_d = 1'b0;
        else if (!wr_count && cnt_inc && (count_nxt == compare_q))
            ti_d = 1'b1;

        if (wr_status) begin
            im_d  = wdata[15:8];
            ie_d  = wdata[0];
            exl_d = wdata[1];
        end

        ip_d[1:0] = wr_cause ? wdata[9:8] : ip_q[1:0];
        ip_d[6:2] = hw_int[4:0];
        ip_d[7]   = hw_int[5] | ti_q;

        if (wr_epc)
            epc_d = wdata;

        if (cp0_exp_en) begin
            exl_d  = 1'b1;
            code_d = cp0_exp_code;
            if (cp0_exp_bad_vaddr_wen)
                badvaddr_d = cp0_exp_bad_vaddr;
            if (first_exc) begin
                epc_d = cp0_exp_epc;
                bd_d  = cp0_exp_bd;
            end
        end else if (cp0_exl_clean) begin
            exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            epc_q      <= '0;
            im_q       <= '0;
            ip_q       <= '0;
            code_q     <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            tog_q      <= 1'b0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            epc_q      <= epc_d;
            im_q       <= im_d;
            ip_q       <= ip_d;
            code_q     <= code_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            tog_q      <= tog_d;
        end
    end

    assign status_w = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    assign cause_w  = {bd_q, ti_q, 14'd0, ip_q, 1'b0, code_q, 2'b00};

    always_comb begin
        rdata = '0;
        case (raddr)
            5'd8:    rdata = badvaddr_q;
            5'd9:    rdata = count_q;
            5'd11:   rdata = compare_q;
            5'd12:   rdata = status_w;
            5'd13:   rdata = cause_w;
            5'd14:   rdata = epc_q;
            5'd15:   rdata = PRID_VALUE;
            default: rdata = '0;
        endcase
    end

    assign epc_address       = epc_q;
    assign status_exl        = exl_q;
    assign timer_int         = ti_q;
    assign interrupt_pending = ie_q && !exl_q && |(ip_q & im_q);

endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: directed and random stimulus against a reference model.
// Two instances: Count every second cycle (main) and every cycle (fast).
module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic [4:0]  raddr_f;
    logic [31:0] rdata_f;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [5:0]  hw_int;
    logic        exp_en, exl_clean, exp_bd, bv_wen;
    logic [31:0] exp_epc, bad_vaddr;
    logic [4:0]  exp_code;
    logic [31:0] epc_address, epc_f;
    logic        status_exl, irq, ti;
    logic        exl_f, irq_f, ti_f;

    int checks = 0;
    int errors = 0;

    // reference state
    logic [31:0] m_bva, m_count, m_cmp, m_epc, mf_count;
    logic [7:0]  m_im, m_ip;
    logic [4:0]  m_code;
    logic        m_exl, m_ie, m_bd, m_ti, m_tog;

    cp0_regfile #(.PRID_VALUE(32'h0001_8000), .COUNT_DIV2(1'b1)) dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata),
        .wen(wen), .waddr(waddr), .wdata(wdata), .hw_int(hw_int),
        .cp0_exp_en(exp_en), .cp0_exl_clean(exl_clean),
        .cp0_exp_epc(exp_epc), .cp0_exp_code(exp_code),
        .cp0_exp_bd(exp_bd), .cp0_exp_bad_vaddr(bad_vaddr),
        .cp0_exp_bad_vaddr_wen(bv_wen),
        .epc_address(epc_address), .status_exl(status_exl),
        .interrupt_pending(irq), .timer_int(ti)
    );

    cp0_regfile #(.PRID_VALUE(32'h0001_8000), .COUNT_DIV2(1'b0)) dut_f (
        .clk(clk), .rst(rst), .raddr(raddr_f), .rdata(rdata_f),
        .wen(wen), .waddr(waddr), .wdata(wdata), .hw_int(hw_int),
        .cp0_exp_en(exp_en), .cp0_exl_clean(exl_clean),
        .cp0_exp_epc(exp_epc), .cp0_exp_code(exp_code),
        .cp0_exp_bd(exp_bd), .cp0_exp_bad_vaddr(bad_vaddr),
        .cp0_exp_bad_vaddr_wen(bv_wen),
        .epc_address(epc_f), .status_exl(exl_f),
        .interrupt_pending(irq_f), .timer_int(ti_f)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a);
        case (a)
            5'd8:    return m_bva;
            5'd9:    return m_count;
            5'd11:   return m_cmp;
            5'd12:   return 32'h0040_0000 | (32'(m_im) << 8)
                            | (32'(m_exl) << 1) | 32'(m_ie);
            5'd13:   return (32'(m_bd) << 31) | (32'(m_ti) << 30)
                            | (32'(m_ip) << 8) | (32'(m_code) << 2);
            5'd14:   return m_epc;
            5'd15:   return 32'h0001_8000;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_bva = 0; m_count = 0; m_cmp = 0; m_epc = 0; mf_count = 0;
        m_im = 0; m_ip = 0; m_code = 0;
        m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_tog = 0;
    endtask

    task automatic check_outs();
        chk("epc", epc_address, m_epc);
        chk("exl", 32'(status_exl), 32'(m_exl));
        chk("timer_int", 32'(ti), 32'(m_ti));
        chk("irq", 32'(irq), 32'(m_ie & ~m_exl & (|(m_ip & m_im))));
        chk("rdata", rdata, mread(raddr));
        chk("count_fast", rdata_f, mf_count);
    endtask

    // one clock edge: predict, clock, compare
    task automatic tick();
        logic wc, wcmp, ws, wca, we, first;
        logic [31:0] n_count, n_cmp, n_epc, n_bva, inc_val;
        logic [7:0]  n_im, n_ip;
        logic [4:0]  n_code;
        logic        n_exl, n_ie, n_bd, n_ti, n_tog;
        wc    = wen && waddr == 5'd9;
        wcmp  = wen && waddr == 5'd11;
        ws    = wen && waddr == 5'd12;
        wca   = wen && waddr == 5'd13;
        we    = wen && waddr == 5'd14;
        first = exp_en && !m_exl;
        inc_val = m_count + 32'd1;
        n_count = wc ? wdata : (m_tog ? inc_val : m_count);
        n_tog   = wc ? 1'b0 : !m_tog;
        if (wcmp) n_ti = 1'b0;
        else if (!wc && m_tog && inc_val == m_cmp) n_ti = 1'b1;
        else n_ti = m_ti;
        n_cmp  = wcmp ? wdata : m_cmp;
        n_im   = ws ? wdata[15:8] : m_im;
        n_ie   = ws ? wdata[0] : m_ie;
        n_ip   = {hw_int[5] | m_ti, hw_int[4:0],
                  wca ? wdata[9:8] : m_ip[1:0]};
        n_exl  = exp_en ? 1'b1 : exl_clean ? 1'b0 : ws ? wdata[1] : m_exl;
        n_epc  = first ? exp_epc : we ? wdata : m_epc;
        n_bd   = first ? exp_bd : m_bd;
        n_code = exp_en ? exp_code : m_code;
        n_bva  = (exp_en && bv_wen) ? bad_vaddr : m_bva;
        @(posedge clk);
        m_count = n_count; m_tog = n_tog; m_ti = n_ti; m_cmp = n_cmp;
        m_im = n_im; m_ie = n_ie; m_ip = n_ip; m_exl = n_exl;
        m_epc = n_epc; m_bd = n_bd; m_code = n_code; m_bva = n_bva;
        mf_count = wc ? wdata : mf_count + 32'd1;
        #1;
        check_outs();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        wen = 1'b1; waddr = a; wdata = d;
        tick();
        wen = 1'b0;
    endtask

    task automatic exc(input logic [31:0] epc, input logic [4:0] code,
                       input logic bd, input logic [31:0] bv,
                       input logic bvw, input logic eret);
        exp_en = 1'b1; exp_epc = epc; exp_code = code; exp_bd = bd;
        bad_vaddr = bv; bv_wen = bvw; exl_clean = eret;
        tick();
        exp_en = 1'b0; bv_wen = 1'b0; exl_clean = 1'b0;
    endtask

    task automatic eret();
        exl_clean = 1'b1;
        tick();
        exl_clean = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a,
                      input logic [31:0] exp);
        raddr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    logic [4:0] addrs [8];

    initial begin
        addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
        rst = 1'b0; raddr = 5'd12; raddr_f = 5'd9;
        wen = 0; waddr = 0; wdata = 0; hw_int = 0;
        exp_en = 0; exl_clean = 0; exp_bd = 0; bv_wen = 0;
        exp_epc = 0; bad_vaddr = 0; exp_code = 0;
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_status", rdata, 32'h0040_0000);
        chk("reset_epc", epc_address, 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_ti", 32'(ti), 32'd0);
        rst = 1'b1;
        tick();

        // first exception captures EPC and BD
        raddr = 5'd13;
        exc(32'hBFC0_0100, 5'h0C, 1'b1, 32'd0, 1'b0, 1'b0);
        chk("exc1_cause", rdata, 32'h8000_0030);
        chk("exc1_epc", epc_address, 32'hBFC0_0100);
        chk("exc1_exl", 32'(status_exl), 32'd1);
        exc(32'h0000_1234, 5'h04, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("exc2_cause", rdata, 32'h8000_0010);
        chk("exc2_epc", epc_address, 32'hBFC0_0100);
        eret();

        // address error loads BadVAddr
        exc(32'h0000_2000, 5'h05, 1'b0, 32'h8000_0003, 1'b1, 1'b0);
        rd("bva", 5'd8, 32'h8000_0003);
        eret();
        chk("eret_exl", 32'(status_exl), 32'd0);
        exc(32'h0000_3000, 5'h01, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("exc_eret_exl", 32'(status_exl), 32'd1);
        eret();

        // timer: Compare=10, Count=0 -> TI after 20 edges
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd11, 32'd10);
        mtc0(5'd9, 32'd0);
        repeat (19) tick();
        chk("ti_early", 32'(ti), 32'd0);
        tick();
        chk("ti_rise", 32'(ti), 32'd1);
        chk("irq_not_yet", 32'(irq), 32'd0);
        tick();
        chk("irq_timer", 32'(irq), 32'd1);
        mtc0(5'd11, 32'd0);
        chk("ti_clear", 32'(ti), 32'd0);
        tick();

        // hardware interrupt line 0
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001;
        tick();
        chk("irq_hw", 32'(irq), 32'd1);
        mtc0(5'd12, 32'h0000_0403);
        chk("irq_exl_mask", 32'(irq), 32'd0);

        // asynchronous reset mid-run
        mtc0(5'd9, 32'd5);
        raddr = 5'd12;
        rst = 1'b0;
        #1;
        model_reset();
        chk("arst_status", rdata, 32'h0040_0000);
        raddr = 5'd9;
        #1;
        chk("arst_count", rdata, 32'd0);
        chk("arst_epc", epc_address, 32'd0);
        chk("arst_exl", 32'(status_exl), 32'd0);
        #1;
        rst = 1'b1;
        hw_int = 6'd0;
        tick();

        // wrap on the fast instance
        mtc0(5'd9, 32'hFFFF_FFFF);
        tick();
        chk("wrap_fast", rdata_f, 32'd0);

        // MTC0 Count alongside an exception still commits
        raddr = 5'd9;
        wen = 1'b1; waddr = 5'd9; wdata = 32'd7;
        exc(32'h0000_4000, 5'h08, 1'b0, 32'd0, 1'b0, 1'b0);
        wen = 1'b0;
        chk("count_with_exc", rdata, 32'd7);
        rd("unmapped", 5'd3, 32'd0);
        rd("prid", 5'd15, 32'h0001_8000);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            hw_int    = 6'($urandom);
            raddr     = addrs[$urandom_range(0, 7)];
            wen       = ($urandom_range(0, 2) == 0);
            waddr     = addrs[$urandom_range(0, 7)];
            wdata     = $urandom;
            if (waddr == 5'd11 && $urandom_range(0, 1) == 1)
                wdata = m_count + 32'($urandom_range(1, 6));
            exp_en    = ($urandom_range(0, 7) == 0);
            exl_clean = ($urandom_range(0, 5) == 0);
            exp_epc   = $urandom;
            exp_code  = 5'($urandom);
            exp_bd    = 1'($urandom);
            bad_vaddr = $urandom;
            bv_wen    = exp_en && ($urandom_range(0, 1) == 1);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
